// File: rtl/booth_seq_mul32.sv
// Sequential radix-4 Booth multiplier, 32x32 -> low 64 bits, one Booth digit per clock.
// Optional signed/unsigned mode input under macro BOOTH_SIGN_CTRL_EN (default: always signed).
module booth_seq_mul32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] product,
  output logic        busy
`ifdef BOOTH_SIGN_CTRL_EN
  ,
  input  logic        is_signed
`endif
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state;
  logic [33:0] a_x;
  logic [34:0] b_sh;
  logic        mode;
  logic [65:0] acc;
  logic [4:0]  k;

  logic        accept_mode;
  logic        ext_a;
  logic        ext_b;
  logic [65:0] a_66;
  logic [65:0] mag;
  logic        neg;
  logic [65:0] pp_bits;
  logic [65:0] acc_next;
  logic        last_iter;

`ifdef BOOTH_SIGN_CTRL_EN
  assign accept_mode = is_signed;
`else
  assign accept_mode = 1'b1;
`endif

  assign ext_a = accept_mode & a[31];
  assign ext_b = accept_mode & b[31];
  assign a_66  = {{32{a_x[33]}}, a_x};

  // b_sh[2:0] is always the current triplet; the appended zero is b[-1].
  always_comb begin
    mag = '0;
    neg = 1'b0;
    case (b_sh[2:0])
      3'b001, 3'b010: mag = a_66;
      3'b011:         mag = a_66 << 1;
      3'b100: begin
        mag = a_66 << 1;
        neg = 1'b1;
      end
      3'b101, 3'b110: begin
        mag = a_66;
        neg = 1'b1;
      end
      default: mag = '0;
    endcase
    // Negation: ones' complement here, carry-in added at the same weight below.
    pp_bits  = neg ? ~mag : mag;
    acc_next = acc + (pp_bits << {k, 1'b0}) + ({65'd0, neg} << {k, 1'b0});
  end

  assign last_iter = mode ? (k == 5'd15) : (k == 5'd16);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_x       <= '0;
      b_sh      <= '0;
      mode      <= 1'b1;
      acc       <= '0;
      k         <= '0;
      product   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_x      <= {ext_a, ext_a, a};
            b_sh     <= {ext_b, ext_b, b, 1'b0};
            mode     <= accept_mode;
            acc      <= '0;
            k        <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= CALC;
          end
        end
        CALC: begin
          acc  <= acc_next;
          k    <= k + 5'd1;
          b_sh <= {b_sh[34], b_sh[34], b_sh[34:2]};
          if (last_iter) begin
            product   <= acc_next[63:0];
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_seq_mul32.sv
// Bench for booth_seq_mul32: directed corner cases plus random operands against a plain-multiply model.
module tb_booth_seq_mul32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] product;
  logic        busy;
  logic        mode_in;

  int  vectors    = 0;
  int  miscompares = 0;
  time last_acc   = 0;

`ifdef BOOTH_SIGN_CTRL_EN
  localparam bit HAS_MODE = 1'b1;
`else
  localparam bit HAS_MODE = 1'b0;
`endif

  always #5 clk = ~clk;

  booth_seq_mul32 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
`ifdef BOOTH_SIGN_CTRL_EN
    ,
    .is_signed (mode_in)
`endif
  );

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y, input bit s);
    logic [63:0] xe;
    logic [63:0] ye;
    xe = s ? {{32{x[31]}}, x} : {32'h0, x};
    ye = s ? {{32{y[31]}}, y} : {32'h0, y};
    return xe * ye;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge with the DUT idle; returns at a falling edge with the DUT idle again.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input bit s,
                        input int stall, input bit keep, input int spacing);
    bit          se;
    int          n;
    int          cnt;
    bit          bad;
    logic [63:0] exp;
    time         t;
    se  = HAS_MODE ? s : 1'b1;
    n   = se ? 16 : 17;
    exp = ref_mul(x, y, se);
    a = x; b = y; mode_in = s; in_valid = 1'b1;
    out_ready = (stall == 0);
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    @(posedge clk);
    t = $time;
    if (spacing > 0) chk("issue_spacing", 64'((t - last_acc) / 10), 64'(spacing));
    last_acc = t;
    #1;
    a = $urandom; b = $urandom; mode_in = 1'($urandom_range(0, 1));
    if (!keep) in_valid = 1'b0;
    cnt = 0;
    bad = 1'b0;
    while (cnt < 40) begin
      @(negedge clk);
      if (out_valid === 1'b1) break;
      if (in_ready !== 1'b0 || busy !== 1'b1) bad = 1'b1;
      cnt++;
    end
    chk("latency", 64'(cnt), 64'(n));
    chk("calc_ready_busy", 64'(bad), 64'd0);
    chk("product", product, exp);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_product", product, exp);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("idle_valid", 64'(out_valid), 64'd0);
    chk("idle_in_ready", 64'(in_ready), 64'd1);
    chk("idle_product_held", product, exp);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; mode_in = 1'b1;
    #12;
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_product", product, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(32'd3, 32'd5, 1'b1, 0, 1'b0, 0);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 0, 1'b0, 18);
    run_op(32'h7FFFFFFF, 32'h80000000, 1'b1, 0, 1'b0, 18);
    run_op(32'h80000000, 32'h80000000, 1'b1, 5, 1'b0, 18);

    // Asynchronous reset in the middle of CALC.
    a = $urandom; b = $urandom; mode_in = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_product", product, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'd2, 32'hFFFFFFFD, 1'b1, 0, 1'b0, 0);

    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0, 1'b0, 0);
    run_op(32'h0, 32'hDEADBEEF, 1'b0, 1, 1'b0, 0);

    // in_valid held high with junk operands while busy.
    for (int i = 0; i < 4; i++)
      run_op($urandom, $urandom, 1'b1, 0, 1'b1, (i == 0) ? 0 : 18);

    for (int i = 0; i < 24; i++)
      run_op($urandom, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'b0, 0);

    in_valid = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
